// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter: FSM states, the
// owner encoding and the line-offset width calculation.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Number of byte-address bits covered by one cache line.
    function automatic int line_off_bits(input int line_beats, input int data_w);
        return $clog2(line_beats * data_w / 8);
    endfunction

endpackage

// File: rtl/mem_arb.sv
// Two-way round-robin arbiter for the external memory port: grants the I-cache
// refill or D-cache refill/writeback side and sequences one line burst at a time.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_trd,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_trd,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_wready,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner,
    output logic [2:0]        owner_trd
);

    localparam int                OFF_BITS   = line_off_bits(LINE_BEATS, DATA_W);
    localparam int                BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_BEATS - 1);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK  = ~((ADDR_W'(1) << OFF_BITS) - ADDR_W'(1));

    state_t            state, state_nxt;
    owner_t            own_q, last_owner, grant_own;
    logic              grant;
    logic              wr_q;
    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        trd_q;
    logic              beat_ack, last_ack;
    logic              in_xfer, d_write;

    assign in_xfer  = (state == XFER);
    assign beat_ack = in_xfer && mem_ack;
    assign last_ack = beat_ack && (beat == LAST_BEAT);
    assign d_write  = in_xfer && wr_q && (own_q == OWN_D);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_own = OWN_I;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant     = 1'b1;
                    state_nxt = XFER;
                    // On a tie the side that did not own the last burst wins.
                    if (i_req && d_req)
                        grant_own = (last_owner == OWN_I) ? OWN_D : OWN_I;
                    else
                        grant_own = d_req ? OWN_D : OWN_I;
                end
            end
            XFER:    if (last_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat       <= '0;
            last_owner <= OWN_I;
            own_q      <= OWN_I;
            trd_q      <= '0;
            wr_q       <= 1'b0;
            base_q     <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (grant) begin
                own_q  <= grant_own;
                trd_q  <= (grant_own == OWN_D) ? d_trd : i_trd;
                wr_q   <= (grant_own == OWN_D) && d_wr;
                base_q <= ((grant_own == OWN_D) ? d_addr : i_addr) & LINE_MASK;
                beat   <= '0;
            end
            if (beat_ack) begin
                beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
                if (!wr_q) begin
                    if (own_q == OWN_D) begin
                        d_rdata  <= mem_rdata;
                        d_rvalid <= 1'b1;
                    end else begin
                        i_rdata  <= mem_rdata;
                        i_rvalid <= 1'b1;
                    end
                end
                if (beat == LAST_BEAT) last_owner <= own_q;
            end
        end
    end

    // Beat-level outputs are gated by state so they fall with reset at once.
    assign mem_req   = in_xfer;
    assign mem_wr    = in_xfer && wr_q;
    assign mem_addr  = in_xfer ? base_q + ADDR_W'(beat) * BEAT_BYTES : '0;
    assign mem_wdata = d_write ? d_wdata : '0;
    assign d_wready  = d_write && mem_ack;
    assign i_done    = (state == DONE) && (own_q == OWN_I);
    assign d_done    = (state == DONE) && (own_q == OWN_D);
    assign busy      = (state != IDLE);
    assign owner     = own_q;
    assign owner_trd = trd_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized bursts
// scored against a transaction-level model of grant order and beat sequence.
module tb_mem_arb;

    localparam int LB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]  i_trd, d_trd;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_rvalid, i_done, d_rvalid, d_wready, d_done;
    logic        mem_req, mem_wr, busy, owner;
    logic [2:0]  owner_trd;

    logic        i_req_s, d_req_s, d_wr_s, mem_ack_s;
    logic [31:0] i_addr_s, d_addr_s, d_wdata_s, mem_rdata_s;
    logic [2:0]  i_trd_s, d_trd_s;
    logic [31:0] i_rdata_s, d_rdata_s, mem_addr_s, mem_wdata_s;
    logic        i_rvalid_s, i_done_s, d_rvalid_s, d_wready_s, d_done_s;
    logic        mem_req_s, mem_wr_s, busy_s, owner_s;
    logic [2:0]  owner_trd_s;

    int          vectors     = 0;
    int          miscompares = 0;
    bit          last_d;
    logic [31:0] wdata_m [LB];

    always #5 clk = ~clk;

    mem_arb #(.LINE_BEATS(LB), .ADDR_W(32), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_trd(i_trd),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_trd(d_trd),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_wready(d_wready), .d_done(d_done),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner), .owner_trd(owner_trd)
    );

    mem_arb #(.LINE_BEATS(1), .ADDR_W(32), .DATA_W(32)) u_dut_single (
        .clk(clk), .rst(rst),
        .i_req(i_req_s), .i_addr(i_addr_s), .i_trd(i_trd_s),
        .i_rdata(i_rdata_s), .i_rvalid(i_rvalid_s), .i_done(i_done_s),
        .d_req(d_req_s), .d_wr(d_wr_s), .d_addr(d_addr_s), .d_wdata(d_wdata_s), .d_trd(d_trd_s),
        .d_rdata(d_rdata_s), .d_rvalid(d_rvalid_s), .d_wready(d_wready_s), .d_done(d_done_s),
        .mem_req(mem_req_s), .mem_wr(mem_wr_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
        .mem_ack(mem_ack_s), .mem_rdata(mem_rdata_s),
        .busy(busy_s), .owner(owner_s), .owner_trd(owner_trd_s)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One granted burst, starting at the negedge just before the grant edge.
    task automatic serve(input bit side_d, input bit wr, input logic [31:0] addr,
                         input logic [2:0] trd, input int ack_mode,
                         input int stall_beat, input int stall_len);
        logic [31:0] base, exp_rd;
        bit          pend, ack;
        int          beat, cyc, stalled;
        base = addr & ~32'hF;
        beat = 0; cyc = 0; stalled = 0; pend = 0; exp_rd = '0;
        for (int k = 0; k < LB; k++) wdata_m[k] = $urandom;
        while (beat < LB) begin
            @(negedge clk);
            cyc++;
            if (cyc > 300) begin
                check("beat_timeout", 64'(beat), 64'(LB));
                return;
            end
            check("mem_req", mem_req, 1);
            check("mem_addr", mem_addr, base + 32'(4 * beat));
            check("mem_wr", mem_wr, wr);
            check("owner", owner, side_d);
            check("owner_trd", owner_trd, trd);
            check("rvalid_own", side_d ? d_rvalid : i_rvalid, pend);
            if (pend) check("rdata", side_d ? d_rdata : i_rdata, exp_rd);
            check("rvalid_other", side_d ? i_rvalid : d_rvalid, 0);
            check("done_early", i_done | d_done, 0);
            d_wdata = (side_d && wr) ? wdata_m[beat] : $urandom;
            case (ack_mode)
                0:       ack = 1'b1;
                1:       ack = (cyc % 2) == 0;
                default: ack = ($urandom_range(0, 2) != 0);
            endcase
            if (beat == stall_beat && stalled < stall_len) begin
                ack = 1'b0;
                stalled++;
            end
            mem_ack   = ack;
            mem_rdata = $urandom;
            #1;
            check("mem_wdata", mem_wdata, (side_d && wr) ? wdata_m[beat] : 32'h0);
            check("d_wready", d_wready, side_d && wr && ack);
            pend   = ack && !wr;
            exp_rd = mem_rdata;
            if (ack) beat++;
        end
        @(negedge clk);
        check("done_mem_req", mem_req, 0);
        check("done_own", side_d ? d_done : i_done, 1);
        check("done_other", side_d ? i_done : d_done, 0);
        check("last_rvalid", side_d ? d_rvalid : i_rvalid, !wr);
        if (!wr) check("last_rdata", side_d ? d_rdata : i_rdata, exp_rd);
        check("done_wready", d_wready, 0);
        if (side_d) d_req = 1'b0;
        else        i_req = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        last_d  = side_d;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_mem_req", mem_req, 0);
        check("idle_flags", {i_rvalid, d_rvalid, i_done, d_done}, 0);
        mem_ack = 1'($urandom_range(0, 1));
    endtask

    // Raise requests with the arbiter idle and serve them in model-predicted order.
    task automatic request(input bit ri, input bit rd, input bit dwr,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [2:0] it, input logic [2:0] dt,
                           input int ack_mode, input int stall_beat, input int stall_len);
        bit first_d;
        i_req = ri; i_addr = ia; i_trd = it;
        d_req = rd; d_wr = dwr; d_addr = da; d_trd = dt;
        first_d = (ri && rd) ? !last_d : rd;
        serve(first_d, first_d && dwr, first_d ? da : ia, first_d ? dt : it,
              ack_mode, stall_beat, stall_len);
        if (ri && rd)
            serve(!first_d, !first_d && dwr, first_d ? ia : da, first_d ? it : dt,
                  ack_mode, -1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i_req = 0; i_addr = '0; i_trd = '0;
        d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0; d_trd = '0;
        mem_ack = 0; mem_rdata = '0;
        i_req_s = 0; i_addr_s = '0; i_trd_s = '0;
        d_req_s = 0; d_wr_s = 0; d_addr_s = '0; d_wdata_s = '0; d_trd_s = '0;
        mem_ack_s = 0; mem_rdata_s = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_owner", {owner, owner_trd}, 0);
        check("rst_flags", {i_rvalid, d_rvalid, i_done, d_done, d_wready}, 0);
        rst    = 1'b0;
        last_d = 1'b0;
        @(negedge clk);

        // Ties right after reset: D first, then I; a second tie picks D again.
        request(1, 1, 0, 32'h0000_5008, 32'h0000_7010, 3'd1, 3'd2, 0, -1, 0);
        request(1, 1, 0, 32'h0000_6000, 32'h0000_9024, 3'd4, 3'd5, 2, -1, 0);

        // I-side line read at an unaligned address, ack every cycle.
        request(1, 0, 0, 32'h0000_104C, 32'h0, 3'd3, 3'd0, 0, -1, 0);

        // D-side writeback, ack every other cycle.
        request(0, 1, 1, 32'h0, 32'h0000_2000, 3'd0, 3'd5, 1, -1, 0);

        // D-side read with a 5-cycle stall on beat 1.
        request(0, 1, 0, 32'h0, 32'hABC0_0000, 3'd0, 3'd7, 0, 1, 5);

        // Reset asserted during beat 2 of a D read.
        d_req = 1; d_wr = 0; d_addr = 32'h0000_3000; d_trd = 3'd6;
        @(negedge clk); mem_ack = 1;
        @(negedge clk); mem_ack = 1;
        @(negedge clk);
        check("abort_pre_req", mem_req, 1);
        check("abort_pre_addr", mem_addr, 32'h0000_3008);
        mem_ack = 0;
        #1 rst = 1'b1;
        #1;
        check("abort_mem_req", mem_req, 0);
        check("abort_busy", busy, 0);
        check("abort_owner", owner, 0);
        check("abort_rvalid", d_rvalid, 0);
        d_req = 0;
        @(negedge clk);
        rst    = 1'b0;
        last_d = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_done", {d_done, i_done, busy}, 0);
        end
        request(1, 0, 0, 32'h0000_0F04, 32'h0, 3'd2, 3'd0, 0, -1, 0);

        // Randomized traffic.
        for (int n = 0; n < 25; n++) begin
            bit ri, rd;
            ri = 1'($urandom_range(0, 1));
            rd = ri ? 1'($urandom_range(0, 1)) : 1'b1;
            request(ri, rd, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    3'($urandom), 3'($urandom), 2,
                    $urandom_range(0, LB), $urandom_range(0, 4));
        end

        // Single-beat build: D read at 0x30.
        d_req_s = 1; d_wr_s = 0; d_addr_s = 32'h0000_0030; d_trd_s = 3'd4;
        @(negedge clk);
        check("s_mem_req", mem_req_s, 1);
        check("s_mem_addr", mem_addr_s, 32'h0000_0030);
        check("s_owner", {owner_s, owner_trd_s}, {1'b1, 3'd4});
        check("s_wr", {mem_wr_s, mem_wdata_s}, 0);
        mem_ack_s = 1; mem_rdata_s = $urandom;
        @(negedge clk);
        check("s_rvalid", d_rvalid_s, 1);
        check("s_rdata", d_rdata_s, mem_rdata_s);
        check("s_done", d_done_s, 1);
        check("s_done_req", mem_req_s, 0);
        check("s_busy_done", busy_s, 1);
        check("s_other", {i_rvalid_s, i_done_s, d_wready_s}, 0);
        d_req_s = 0; mem_ack_s = 0;
        @(negedge clk);
        check("s_busy_idle", busy_s, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates the single external memory port between the I-cache refill side and the D-cache refill/writeback side.
- Sequences line-sized bursts of LINE_BEATS word beats and returns read data, write-beat acknowledges and completion pulses to the owning side.
- Tags each transfer with the requesting hardware thread so the stall/flush logic knows whose miss is in flight.
- Sits between the cache miss handlers (fed by the fetch stage and the memory-access stage's d_rd/d_wr/d_miss path) and the memory model/bus.

Parameters:
LINE_BEATS, 4, words per line transfer; power of two, >=1
ADDR_W, 32, address width
DATA_W, 32, data/beat width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_req  in  1  I-side line-read request; held until i_done
i_addr  in  ADDR_W  I-side miss address; any byte in the line
i_trd  in  3  I-side thread id
i_rdata  out  DATA_W  returned read beat
i_rvalid  out  1  i_rdata valid, one pulse per beat
i_done  out  1  I transfer complete, one-cycle pulse
d_req  in  1  D-side request; held until d_done
d_wr  in  1  1 = line writeback, 0 = line read
d_addr  in  ADDR_W  D-side address
d_wdata  in  DATA_W  current write beat
d_trd  in  3  D-side thread id
d_rdata  out  DATA_W  returned read beat
d_rvalid  out  1  d_rdata valid
d_wready  out  1  current d_wdata beat accepted; advance to next beat
d_done  out  1  D transfer complete pulse
mem_req  out  1  beat request to memory
mem_wr  out  1  beat is a write
mem_addr  out  ADDR_W  beat word address
mem_wdata  out  DATA_W  write beat data
mem_ack  in  1  memory accepted/completed current beat
mem_rdata  in  DATA_W  read data, valid with mem_ack
busy  out  1  state != IDLE
owner  out  1  0 = I side, 1 = D side
owner_trd  out  3  thread id of the current transfer

Behaviour:
- Reset asserted (asynchronous, takes effect immediately, also mid-burst): state=IDLE, beat=0, last_owner=I, all outputs 0 (mem_req drops in the same cycle). The aborted transfer gets no done pulse.
- States: IDLE, XFER, DONE.
- IDLE: samples i_req/d_req. Only one asserted -> grant it. Both asserted -> grant the side that is not last_owner; after reset D wins the first tie.
  - On grant, latch owner, owner_trd, wr (d_wr for D, 0 for I), base = addr with the low log2(LINE_BEATS*DATA_W/8) bits cleared, beat=0. Go to XFER.
- XFER:
  - mem_req=1, mem_wr=wr, mem_addr = base + beat*(DATA_W/8), mem_wdata = d_wdata (combinational pass-through when owner=D and wr=1, else 0).
  - mem_req stays high with stable addr/data until mem_ack.
  - On mem_ack: beat increments (wraps to 0 on the last beat).
  - Write: d_wready = mem_ack in the same cycle.
  - Read: the owner's rdata is registered from mem_rdata and its rvalid pulses the next cycle.
  - On mem_ack with beat==LINE_BEATS-1, go to DONE and update last_owner=owner.
- DONE: mem_req=0. The owner's done pulses for 1 cycle, coincident with the final rvalid for reads. Go to IDLE.
- Requests are not sampled in XFER or DONE.
  - Minimum gap is DONE + IDLE = 2 cycles with mem_req=0 between bursts.
  - Grant latency is 1 cycle: req seen in IDLE, mem_req high next cycle.
- A request dropped mid-transfer is ignored; the burst completes.
- A req still high in IDLE after its done is treated as a new request; requesters must deassert in the done cycle.
- i_wdata does not exist; the I side never writes.
- The non-owner side's rvalid/done/wready stay 0 throughout.
- LINE_BEATS=1: beat counter is 1 bit and fixed at 0; a single ack goes to DONE.
- mem_ack outside XFER is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, XFER, DONE}
  - owner enum {OWN_I=1'b0, OWN_D=1'b1}
  - function computing line offset bits from LINE_BEATS/DATA_W
- No sub-module; the 2-way round-robin pick is a few lines inline.

Test Plan:
- Reset, then i_req=1 with i_addr=0x0000_104C (i_trd=3), mem_ack every cycle -> mem_req rises 1 cycle later. mem_addr 0x1040, 0x1044, 0x1048, 0x104C; 4 i_rvalid pulses carrying mem_rdata; i_done coincident with the 4th; owner_trd=3.
- i_req and d_req rise in the same cycle right after reset -> D granted first. I granted in the IDLE following d_done. A further simultaneous request then picks D (last_owner=I).
- d_req, d_wr=1, d_addr=0x2000, mem_ack on every other cycle -> mem_wr=1. Each beat's d_wdata is held until its ack; d_wready pulses exactly 4 times aligned to mem_ack; d_rvalid never asserts; d_done after beat 3.
- Read burst with mem_ack held low 5 cycles on beat 1 -> mem_addr stays 0x..04 and mem_req stays high; no rvalid during the stall.
- Assert rst during beat 2 of a D read -> mem_req, busy and owner are 0 immediately; no d_done. After release, a new i_req is granted normally.
- LINE_BEATS=1 build, d_req read at 0x30 -> single beat at 0x30, d_rvalid and d_done in the same cycle, busy low 2 cycles later.
